// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
// The master side is the operand source and result consumer.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 6
);
  localparam int MW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             eq;
  logic [MW-1:0]    match_cnt;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, eq, match_cnt
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, eq, match_cnt
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with equality flag, match popcount
// and a saturating count of equal-operand output transfers.
module bitwise_logic_pipe #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_logic_pipe_if.slave  bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     eq_count
);
  localparam int MW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_XNOR   = 3'b011,
    OP_NAND   = 3'b100,
    OP_NOR    = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_result;
  logic [WIDTH-1:0] s1_x;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_eq;
  logic [MW-1:0]    s2_match;
  logic             s1_en;
  logic             s2_en;
  logic [WIDTH-1:0] op_result;
  logic [MW-1:0]    popcnt;

  assign s2_en       = !s2_valid || bus.out_ready;
  assign s1_en       = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  always_comb begin
    op_result = '0;
    case (op_e'(bus.op))
      OP_AND:    op_result = bus.a & bus.b;
      OP_OR:     op_result = bus.a | bus.b;
      OP_XOR:    op_result = bus.a ^ bus.b;
      OP_XNOR:   op_result = bus.a ~^ bus.b;
      OP_NAND:   op_result = ~(bus.a & bus.b);
      OP_NOR:    op_result = ~(bus.a | bus.b);
      OP_PASS_A: op_result = bus.a;
      OP_NOT_A:  op_result = ~bus.a;
      default:   op_result = '0;
    endcase
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + MW'(s1_x[i]);
    end
  end

  // Data registers load on every enabled edge, bubbles included; valid bits mask them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_x      <= '0;
    end else if (s1_en) begin
      s1_valid  <= bus.in_valid;
      s1_result <= op_result;
      s1_x      <= bus.a ~^ bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_eq     <= 1'b0;
      s2_match  <= '0;
    end else if (s2_en) begin
      s2_valid  <= s1_valid;
      s2_result <= s1_result;
      s2_eq     <= &s1_x;
      s2_match  <= popcnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_count <= '0;
    end else if (clr_stats) begin
      eq_count <= '0;
    end else if (s2_valid && bus.out_ready && s2_eq && (eq_count != '1)) begin
      eq_count <= eq_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.eq        = s2_eq;
  assign bus.match_cnt = s2_match;
endmodule
